// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants, CTRL byte layout, FSM state type and a
// value-assembly helper for the seven-segment display controller.
// SEG_DISP_CHKSUM_EN adds the CHK state for the optional checksum byte.
package seg_disp_pkg;

  // Frame header and largest value the six-digit display can show
  localparam logic [7:0]  HDR_BYTE = 8'hA5;
  localparam logic [19:0] MAX_VAL  = 20'd999999;

  // CTRL byte layout
  localparam int CTRL_SIGN_BIT  = 7;
  localparam int CTRL_RSVD_BIT  = 6;
  localparam int CTRL_POINT_MSB = 5;
  localparam int CTRL_POINT_LSB = 0;

  // Receive FSM states; each accepted byte advances one state
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_V2,
    ST_V1,
    ST_V0,
`ifdef SEG_DISP_CHKSUM_EN
    ST_CHK,
`endif
    ST_COMMIT
  } state_e;

  // Joins the three value bytes; only the low nibble of V2 carries value bits
  function automatic logic [19:0] frame_value(input logic [3:0] v2_lo,
                                              input logic [7:0] v1,
                                              input logic [7:0] v0);
    return {v2_lo, v1, v0};
  endfunction

endpackage

// File: rtl/seg_us_tick.sv
// seg_us_tick: divides the system clock down to a one-cycle-wide 1 us tick.
// CLK_FREQ must be an integer multiple of 1 MHz; at exactly 1 MHz the tick
// is high every cycle.
module seg_us_tick #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int            DIV  = CLK_FREQ / 1_000_000;
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Free-running modulo-DIV counter that wraps on the tick cycle
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Divider counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: parses framed RS485 bytes into a validated display word,
// holds the last good frame and blanks the display when the link goes quiet.
// Define SEG_DISP_CHKSUM_EN for the 6-byte frame with an XOR checksum byte;
// without it the frame is 5 bytes and validation runs on V0.
module seg_disp_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BYTE_TO_US = 2000,
  parameter int HOLD_MS    = 3000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        en,
  output logic        frame_ok,
  output logic [7:0]  err_cnt
);

  import seg_disp_pkg::*;

  localparam int            HOLD_US   = HOLD_MS * 1000;
  localparam int            BW        = $clog2(BYTE_TO_US + 1);
  localparam int            HW        = (HOLD_US > 0) ? $clog2(HOLD_US + 1) : 1;
  localparam logic [BW-1:0] BYTE_LIM  = BW'(BYTE_TO_US);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTE_TO_US - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_US > 0) ? HOLD_US - 1 : 0);
  localparam logic          HOLD_EN   = (HOLD_MS != 0);

  state_e        state_q, state_d;

  logic [7:0]    ctrl_q, v2_q, v1_q, v0_q;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [19:0]   data_q, data_d;
  logic [5:0]    point_q, point_d;
  logic          sign_q, sign_d;
  logic          en_q, en_d;
  logic          frame_ok_q, frame_ok_d;
  logic [7:0]    err_q, err_d;

  logic          us_tick;
  logic          in_frame;
  logic          byte_to;
  logic          hold_to;

  logic [7:0]    last_v0;
  logic          chk_ok;
  logic [19:0]   cand_value;
  logic          frame_valid;

  logic          cap_ctrl, cap_v2, cap_v1, cap_v0;
  logic          last_byte;
  logic          commit;
  logic          reject;
  logic          err_inc;

  seg_us_tick #(
    .CLK_FREQ(CLK_FREQ)
  ) u_us_tick (
    .clk_i  (sys_clk),
    .rst_n_i(sys_rst_n),
    .tick_o (us_tick)
  );

  // Byte timeout only guards the inside of a frame, and a byte in the same
  // cycle always wins over the timeout
  assign in_frame = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
  assign byte_to  = in_frame && us_tick && !rx_valid && (byte_cnt_q == BYTE_LAST);
  assign hold_to  = HOLD_EN && en_q && us_tick && (hold_cnt_q == HOLD_LAST);

  // Frame validation, evaluated against the byte arriving in the final state
  always_comb begin
`ifdef SEG_DISP_CHKSUM_EN
    last_v0 = v0_q;
    chk_ok  = (rx_data == (ctrl_q ^ v2_q ^ v1_q ^ v0_q));
`else
    last_v0 = rx_data;
    chk_ok  = 1'b1;
`endif
    cand_value  = frame_value(v2_q[3:0], v1_q, last_v0);
    frame_valid = (cand_value <= MAX_VAL) &&
                  !ctrl_q[CTRL_RSVD_BIT] &&
                  (v2_q[7:4] == 4'h0) &&
                  chk_ok;
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one state per byte, no resync on a header inside a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == HDR_BYTE)) state_d = ST_CTRL;
      end
      ST_CTRL: begin
        if (rx_valid)     state_d = ST_V2;
        else if (byte_to) state_d = ST_IDLE;
      end
      ST_V2: begin
        if (rx_valid)     state_d = ST_V1;
        else if (byte_to) state_d = ST_IDLE;
      end
      ST_V1: begin
        if (rx_valid)     state_d = ST_V0;
        else if (byte_to) state_d = ST_IDLE;
      end
`ifdef SEG_DISP_CHKSUM_EN
      ST_V0: begin
        if (rx_valid)     state_d = ST_CHK;
        else if (byte_to) state_d = ST_IDLE;
      end
      ST_CHK: begin
        if (rx_valid)     state_d = frame_valid ? ST_COMMIT : ST_IDLE;
        else if (byte_to) state_d = ST_IDLE;
      end
`else
      ST_V0: begin
        if (rx_valid)     state_d = frame_valid ? ST_COMMIT : ST_IDLE;
        else if (byte_to) state_d = ST_IDLE;
      end
`endif
      ST_COMMIT: begin
        state_d = (rx_valid && (rx_data == HDR_BYTE)) ? ST_CTRL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: byte capture strobes, commit and error events
  always_comb begin
    cap_ctrl  = 1'b0;
    cap_v2    = 1'b0;
    cap_v1    = 1'b0;
    cap_v0    = 1'b0;
    last_byte = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_CTRL:   cap_ctrl = rx_valid;
      ST_V2:     cap_v2   = rx_valid;
      ST_V1:     cap_v1   = rx_valid;
`ifdef SEG_DISP_CHKSUM_EN
      ST_V0:     cap_v0    = rx_valid;
      ST_CHK:    last_byte = rx_valid;
`else
      ST_V0: begin
        cap_v0    = rx_valid;
        last_byte = rx_valid;
      end
`endif
      ST_COMMIT: commit = 1'b1;
      default: ;
    endcase
    reject  = last_byte && !frame_valid;
    err_inc = reject || byte_to;
  end

  // Frame byte capture, held until the commit cycle copies them out
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ctrl_q <= '0;
      v2_q   <= '0;
      v1_q   <= '0;
      v0_q   <= '0;
    end else begin
      if (cap_ctrl) ctrl_q <= rx_data;
      if (cap_v2)   v2_q   <= rx_data;
      if (cap_v1)   v1_q   <= rx_data;
      if (cap_v0)   v0_q   <= rx_data;
    end
  end

  // Timer next-state: byte gap restarts on every byte, hold restarts on commit
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (rx_valid) begin
      byte_cnt_d = '0;
    end else if (us_tick && (byte_cnt_q != BYTE_LIM)) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
    end

    hold_cnt_d = hold_cnt_q;
    if (commit) begin
      hold_cnt_d = '0;
    end else if (HOLD_EN && en_q && us_tick && (hold_cnt_q != HOLD_LAST)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Timer registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Display word next-state: load on commit, blank on hold expiry, count errors
  always_comb begin
    data_d     = data_q;
    point_d    = point_q;
    sign_d     = sign_q;
    en_d       = en_q;
    frame_ok_d = commit;
    err_d      = err_q;
    if (commit) begin
      data_d  = frame_value(v2_q[3:0], v1_q, v0_q);
      point_d = ctrl_q[CTRL_POINT_MSB:CTRL_POINT_LSB];
      sign_d  = ctrl_q[CTRL_SIGN_BIT];
      en_d    = 1'b1;
    end else if (hold_to) begin
      en_d    = 1'b0;
    end
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Display word and status registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_q     <= '0;
      point_q    <= '0;
      sign_q     <= 1'b0;
      en_q       <= 1'b0;
      frame_ok_q <= 1'b0;
      err_q      <= '0;
    end else begin
      data_q     <= data_d;
      point_q    <= point_d;
      sign_q     <= sign_d;
      en_q       <= en_d;
      frame_ok_q <= frame_ok_d;
      err_q      <= err_d;
    end
  end

  assign data     = data_q;
  assign point    = point_q;
  assign sign     = sign_q;
  assign en       = en_q;
  assign frame_ok = frame_ok_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl: drives directed and random RS485 frames into
// seg_disp_ctrl and compares the display word against a frame-level model.
// Frame length follows SEG_DISP_CHKSUM_EN, as in the design.
`timescale 1ns/1ps
module tb_seg_disp_ctrl;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BYTE_TO_US = 20;
  localparam int HOLD_MS    = 1;
  localparam int HOLD_CYC   = HOLD_MS * 1000 * (CLK_FREQ / 1_000_000);
`ifdef SEG_DISP_CHKSUM_EN
  localparam int NKINDS = 5;
`else
  localparam int NKINDS = 4;
`endif

  logic        sysClk = 1'b0;
  logic        sysRstN;
  logic        rxValid;
  logic [7:0]  rxData;
  logic [19:0] dataOut;
  logic [5:0]  pointOut;
  logic        signOut;
  logic        enOut;
  logic        frameOk;
  logic [7:0]  errCnt;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] txBytes[$];
  int expData, expPoint, expSign, expErr;
  bit committedOnce;
  int commitCyc;

  seg_disp_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .BYTE_TO_US(BYTE_TO_US),
    .HOLD_MS   (HOLD_MS)
  ) dut (
    .sys_clk  (sysClk),
    .sys_rst_n(sysRstN),
    .rx_valid (rxValid),
    .rx_data  (rxData),
    .data     (dataOut),
    .point    (pointOut),
    .sign     (signOut),
    .en       (enOut),
    .frame_ok (frameOk),
    .err_cnt  (errCnt)
  );

  // 100 MHz simulation clock; the DUT is told it runs at 1 MHz so one cycle is one us
  always #5 sysClk = ~sysClk;

  // Cycle counter used to place the hold-timeout boundary
  always @(posedge sysClk) cyc <= cyc + 1;

  // Hard stop in case something hangs
  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Display stays lit for HOLD_CYC cycles after the commit edge
  function automatic bit expectedEn();
    return committedOnce && ((cyc - commitCyc) < HOLD_CYC);
  endfunction

  task automatic checkDisplay(input string tag);
    checkOutput($sformatf("%s.data", tag),  dataOut,  expData);
    checkOutput($sformatf("%s.point", tag), pointOut, expPoint);
    checkOutput($sformatf("%s.sign", tag),  signOut,  expSign);
    checkOutput($sformatf("%s.en", tag),    enOut,    expectedEn());
    checkOutput($sformatf("%s.err", tag),   errCnt,   expErr);
  endtask

  function automatic int frameValue();
    return (txBytes[2] % 16) * 65536 + txBytes[3] * 256 + txBytes[4];
  endfunction

  function automatic bit frameIsGood();
    bit good;
    good = (frameValue() <= 999999) && (((txBytes[1] / 64) % 2) == 0) && (txBytes[2] < 16);
`ifdef SEG_DISP_CHKSUM_EN
    good = good && (txBytes[5] == (txBytes[1] ^ txBytes[2] ^ txBytes[3] ^ txBytes[4]));
`endif
    return good;
  endfunction

  task automatic buildFrame(input logic [7:0] ctrl, input logic [7:0] v2,
                            input logic [7:0] v1, input logic [7:0] v0);
    txBytes.delete();
    txBytes.push_back(8'hA5);
    txBytes.push_back(ctrl);
    txBytes.push_back(v2);
    txBytes.push_back(v1);
    txBytes.push_back(v0);
`ifdef SEG_DISP_CHKSUM_EN
    txBytes.push_back(ctrl ^ v2 ^ v1 ^ v0);
`endif
  endtask

  // kind 0 good, 1 over range, 2 reserved bit, 3 V2 high nibble, 4 bad checksum
  task automatic buildRandomFrame(input int kind);
    int value;
    logic [7:0] ctrl;
    logic [7:0] v2;
    ctrl = 8'($urandom);
    ctrl[6] = 1'b0;
    value = int'($urandom_range(0, 999999));
    if (kind == 1) value = int'($urandom_range(1_000_000, 1_048_575));
    if (kind == 2) ctrl[6] = 1'b1;
    v2 = 8'(value / 65536);
    if (kind == 3) v2 = v2 + 8'(16 * $urandom_range(1, 15));
    buildFrame(ctrl, v2, 8'((value / 256) % 256), 8'(value % 256));
`ifdef SEG_DISP_CHKSUM_EN
    if (kind == 4) txBytes[5] = txBytes[5] ^ (8'd1 << $urandom_range(0, 7));
`endif
  endtask

  // Drives one byte for one cycle; called and returns at a falling edge
  task automatic sendByte(input logic [7:0] b);
    rxValid = 1'b1;
    rxData  = b;
    @(negedge sysClk);
    rxValid = 1'b0;
    rxData  = 8'($urandom);
  endtask

  task automatic applyStimulus(input int gap);
    foreach (txBytes[i]) begin
      if (i > 0) repeat (gap) @(negedge sysClk);
      sendByte(txBytes[i]);
    end
  endtask

  task automatic modelCommit();
    expData       = frameValue();
    expPoint      = txBytes[1] % 64;
    expSign       = txBytes[1] / 128;
    committedOnce = 1'b1;
    commitCyc     = cyc;
  endtask

  // Called at the falling edge right after the final byte was sampled
  task automatic checkFrameResult(input string tag);
    if (frameIsGood()) begin
      checkOutput($sformatf("%s.okEarly", tag), frameOk, 0);
      @(negedge sysClk);
      modelCommit();
      checkOutput($sformatf("%s.okPulse", tag), frameOk, 1);
      checkDisplay(tag);
      @(negedge sysClk);
      checkOutput($sformatf("%s.okDrop", tag), frameOk, 0);
    end else begin
      expErr = (expErr < 255) ? expErr + 1 : 255;
      checkOutput($sformatf("%s.okNone", tag), frameOk, 0);
      checkDisplay(tag);
      @(negedge sysClk);
      checkOutput($sformatf("%s.okNone2", tag), frameOk, 0);
    end
  endtask

  task automatic resetModel();
    expData = 0; expPoint = 0; expSign = 0; expErr = 0;
    committedOnce = 1'b0;
    commitCyc = 0;
  endtask

  initial begin
    logic [7:0] junk;
    sysRstN = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    resetModel();
    repeat (3) @(negedge sysClk);
    checkDisplay("reset");
    checkOutput("reset.ok", frameOk, 0);
    sysRstN = 1'b1;
    @(negedge sysClk);

    $display("[TB] reference frame");
    buildFrame(8'h8A, 8'h01, 8'hE2, 8'h3F);
    applyStimulus(0);
    checkFrameResult("spec");
    checkOutput("spec.value", dataOut, 123455);
    checkOutput("spec.point6", pointOut, 6'b001010);
    checkOutput("spec.signOn", signOut, 1);

    $display("[TB] range boundaries");
    buildFrame(8'h00, 8'h0F, 8'h42, 8'h40);
    applyStimulus(0);
    checkFrameResult("over");
    checkOutput("over.errOne", errCnt, 1);
    buildFrame(8'h3F, 8'h0F, 8'h42, 8'h3F);
    applyStimulus(1);
    checkFrameResult("max");
    checkOutput("max.value", dataOut, 999999);

`ifdef SEG_DISP_CHKSUM_EN
    $display("[TB] checksum corruption");
    buildFrame(8'h8A, 8'h01, 8'hE2, 8'h3F);
    txBytes[5] = txBytes[5] ^ 8'h01;
    applyStimulus(0);
    checkFrameResult("badChk");
    buildFrame(8'h05, 8'h00, 8'h12, 8'h34);
    applyStimulus(2);
    checkFrameResult("afterChk");
`endif

    $display("[TB] byte timeout");
    buildFrame(8'h01, 8'h02, 8'h03, 8'h04);
    for (int i = 0; i < 3; i++) sendByte(txBytes[i]);
    repeat (BYTE_TO_US - 1) @(negedge sysClk);
    checkOutput("to.before", errCnt, expErr);
    @(negedge sysClk);
    expErr++;
    checkOutput("to.fire", errCnt, expErr);
    repeat (5) @(negedge sysClk);
    checkOutput("to.quiet", errCnt, expErr);
    applyStimulus(0);
    checkFrameResult("afterTo");
    buildFrame(8'h40 ^ 8'h40, 8'h07, 8'h65, 8'h43);
    applyStimulus(BYTE_TO_US - 1);
    checkFrameResult("gapEdge");

    $display("[TB] header during commit");
    buildFrame(8'h81, 8'h00, 8'h00, 8'h2A);
    applyStimulus(0);
    checkOutput("b2b.okEarly", frameOk, 0);
    sendByte(8'hA5);
    modelCommit();
    checkOutput("b2b.okPulse", frameOk, 1);
    checkDisplay("b2b.first");
    buildFrame(8'h02, 8'h01, 8'h00, 8'h00);
    for (int i = 1; i < txBytes.size(); i++) sendByte(txBytes[i]);
    checkFrameResult("b2b.second");

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        sendByte(junk);
      end
      repeat ($urandom_range(0, 3)) @(negedge sysClk);
      buildRandomFrame(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, NKINDS - 1)));
      applyStimulus(int'($urandom_range(0, BYTE_TO_US - 1)));
      checkFrameResult($sformatf("rnd%0d", n));
    end

    $display("[TB] hold timeout");
    buildFrame(8'h20, 8'h03, 8'h21, 8'h09);
    applyStimulus(0);
    checkFrameResult("hold");
    while ((cyc - commitCyc) < HOLD_CYC - 1) @(negedge sysClk);
    checkOutput("hold.lastLit", enOut, 1);
    @(negedge sysClk);
    checkOutput("hold.blank", enOut, 0);
    checkDisplay("hold.kept");
    buildFrame(8'h01, 8'h00, 8'h00, 8'h07);
    applyStimulus(0);
    checkFrameResult("hold.relit");

    $display("[TB] error saturation");
    for (int n = 0; n < 300; n++) begin
      buildRandomFrame(2);
      applyStimulus(0);
      checkFrameResult("sat");
    end
    checkOutput("sat.final", errCnt, 255);

    $display("[TB] reset mid-frame");
    buildFrame(8'h8A, 8'h01, 8'hE2, 8'h3F);
    applyStimulus(0);
    checkFrameResult("preRst");
    sendByte(8'hA5);
    sendByte(8'h11);
    #3;
    sysRstN = 1'b0;
    #1;
    resetModel();
    checkDisplay("rst");
    checkOutput("rst.ok", frameOk, 0);
    @(negedge sysClk);
    sysRstN = 1'b1;
    @(negedge sysClk);
    buildFrame(8'h04, 8'h00, 8'h30, 8'h39);
    applyStimulus(0);
    checkFrameResult("postRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
